axis_frame_len_check: RTL
=========================

AXIS_FRAME_LEN_CHECK -- requirements
Module: axis_frame_len_check

Placement: directly upstream of the stream FIFO. Validates frame length in beats, truncates oversize frames and tags bad frames through tuser[0].

Interface
REQ-001 Parameter DATA_W, default 8: tdata width in bits.
REQ-002 Parameter KEEP_W, default (DATA_W+7)/8: tkeep width.
REQ-003 Parameter USR_W, default 1, minimum 1: tuser width; bit 0 is the bad-frame flag.
REQ-004 Parameter MIN_LEN, default 1: minimum legal frame length in beats; range 1..MAX_LEN.
REQ-005 Parameter MAX_LEN, default 64: maximum legal frame length in beats; must be 2 or more.
REQ-006 clk  input  1  clock; all logic on the rising edge.
REQ-007 srst_n  input  1  reset, synchronous, active-low.
REQ-008 s_axis  axis_full_if.in  -  input stream: tdata, tkeep, tlast, tid, tdest, tuser, tvalid, tready.
REQ-009 m_axis  axis_full_if.out  -  checked output stream, same fields as s_axis.
REQ-010 stat_good_frame  output  1  one-cycle pulse per good frame forwarded.
REQ-011 stat_bad_frame  output  1  one-cycle pulse per bad frame (undersize, oversize, or input-flagged).
REQ-012 stat_frame_len  output  $clog2(MAX_LEN+1)  beats forwarded in the most recently completed frame.
REQ-013 stat_good_cnt, stat_bad_cnt  output  32 each  frame counters; see Configuration.

Function
REQ-014 The output path shall be one register stage: an accepted beat appears on m_axis the next cycle (latency 1).
REQ-015 In the IDLE and ACTIVE states, s_axis.tready shall equal m_axis.tready OR NOT m_axis.tvalid.
REQ-016 m_axis payload and tvalid shall be held stable while m_axis.tvalid=1 and m_axis.tready=0.
REQ-017 The FSM shall have three states: IDLE (no beat of the current frame accepted), ACTIVE, and DROP.
REQ-018 beat_cnt shall be set to 1 on the first accepted beat and incremented on each later accepted beat; it shall never exceed MAX_LEN.
REQ-019 Transition IDLE->ACTIVE shall occur on an accepted beat with tlast=0 when MAX_LEN>1.
REQ-020 An accepted beat with tlast=1 in IDLE or ACTIVE shall return the FSM to IDLE and clear beat_cnt.
REQ-021 Undersize (tlast=1 with beat_cnt<MIN_LEN): the beat shall be forwarded with tuser[0]=1 and stat_bad_frame pulsed.
REQ-022 Legal end (MIN_LEN<=beat_cnt<=MAX_LEN): tuser[0] shall pass through; stat_good_frame pulses if input tuser[0]=0, otherwise stat_bad_frame pulses.
REQ-023 Oversize: an accepted beat with beat_cnt=MAX_LEN and tlast=0 shall be forwarded with tlast forced 1 and tuser[0]=1, stat_bad_frame pulsed, and the FSM moved to DROP.
REQ-024 In DROP, s_axis.tready shall be 1, beats shall be discarded with no m_axis.tvalid, and the FSM shall go to IDLE on an accepted tlast without any further pulse.
REQ-025 Stat pulses and stat_frame_len updates shall occur in the cycle the terminating beat is loaded into the output register.
REQ-026 tdata, tkeep, tid, tdest and tuser[USR_W-1:1] shall pass through unmodified.
REQ-027 A frame exactly MAX_LEN beats long ending with tlast shall be legal and shall not enter DROP.

Reset
REQ-028 On srst_n=0 at a clock edge: m_axis.tvalid=0, FSM=IDLE, beat_cnt=0, stat_good_frame=0, stat_bad_frame=0, stat_frame_len=0, counters=0.
REQ-029 s_axis.tready shall be 0 while srst_n=0.
REQ-030 A reset mid-frame shall abandon the partial frame silently; the next accepted beat starts a new frame at beat_cnt=1.

Configuration
REQ-031 With macro AXIS_FRAME_LEN_CHECK_STATS_EN defined, stat_good_cnt and stat_bad_cnt shall increment on the respective pulses and saturate at 32'hFFFF_FFFF.
REQ-032 Without AXIS_FRAME_LEN_CHECK_STATS_EN, both counter ports shall be tied to 0 and no counter flops shall be inferred; all other behaviour is unchanged.

Verification
All scenarios use DATA_W=8, MIN_LEN=2, MAX_LEN=4, m_axis.tready=1 unless stated.
REQ-033 Send 3-beat frame 0x11,0x22,0x33(tlast) -> identical beats out 1 cycle later, tuser[0]=0, stat_good_frame pulses once, stat_frame_len=3.
REQ-034 Send 1-beat frame 0xAA(tlast) -> 0xAA out with tlast=1, tuser[0]=1, stat_bad_frame pulses once.
REQ-035 Send 6-beat frame 0x01..0x06 -> 0x01..0x04 out, 0x04 with tlast=1 and tuser[0]=1; 0x05 and 0x06 accepted with tready=1 but not output; one stat_bad_frame pulse.
REQ-036 Hold m_axis.tready=0 for 3 cycles mid-frame -> s_axis.tready=0, output beat stable, no beat lost or duplicated after release.
REQ-037 Assert srst_n=0 after beat 2 of a 4-beat frame, then send 2-beat frame 0x7,0x8 -> m_axis.tvalid=0 the cycle after reset; new frame is forwarded good with stat_frame_len=2.
REQ-038 With STATS_EN, send 2 back-to-back 4-beat frames then one 5-beat frame -> stat_good_cnt=2, stat_bad_cnt=1; without STATS_EN both read 0.

Source files
------------

// File: rtl/axis_full_if.sv
// -----------------------------------------------------------------------------
// axis_full_if -- AXI4-Stream bundle carrying the full sideband set.
//
// Parameters: DATA_W, KEEP_W, USR_W, ID_W, DEST_W set the field widths.
// Signals   : tdata, tkeep, tlast, tid, tdest, tuser, tvalid, tready.
// Modports  : out / master -- stream source (drives payload + tvalid)
//             in  / slave  -- stream sink   (drives tready)
//
// Handshake: a beat transfers on a rising edge where tvalid && tready are both
// 1. Once the source raises tvalid it holds tvalid and the whole payload
// stable until that transfer; the sink may raise or drop tready freely.
// -----------------------------------------------------------------------------
interface axis_full_if #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = (DATA_W + 7) / 8,
    parameter int USR_W  = 1,
    parameter int ID_W   = 1,
    parameter int DEST_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USR_W-1:0]  tuser;
    logic              tvalid;
    logic              tready;

    modport out (
        output tdata, tkeep, tlast, tid, tdest, tuser, tvalid,
        input  tready
    );

    modport in (
        input  tdata, tkeep, tlast, tid, tdest, tuser, tvalid,
        output tready
    );

    modport master (
        output tdata, tkeep, tlast, tid, tdest, tuser, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tlast, tid, tdest, tuser, tvalid,
        output tready
    );
endinterface

// File: rtl/axis_frame_len_check.sv
// -----------------------------------------------------------------------------
// axis_frame_len_check -- frame length checker in front of the stream FIFO.
//
// Counts beats per frame, forwards frames through a single output register,
// tags undersize / oversize / input-flagged frames with tuser[0]=1, and cuts
// oversize frames at MAX_LEN beats (forced tlast) while swallowing the rest.
//
// Ports:
//   clk              rising-edge clock
//   srst_n           synchronous active-low reset
//   s_axis           input stream  (axis_full_if.in)
//   m_axis           output stream (axis_full_if.out), latency 1
//   stat_good_frame  1-cycle pulse per good frame forwarded
//   stat_bad_frame   1-cycle pulse per bad frame
//   stat_frame_len   beats forwarded in the last completed frame
//   stat_good_cnt    saturating good-frame counter (0 unless stats enabled)
//   stat_bad_cnt     saturating bad-frame counter  (0 unless stats enabled)
//   dbg_state        current FSM state (0 IDLE, 1 ACTIVE, 2 DROP)
//
// Build option: define AXIS_FRAME_LEN_CHECK_STATS_EN to get the two 32-bit
// frame counters; without it they are constant 0 and no flops exist.
// -----------------------------------------------------------------------------
module axis_frame_len_check #(
    parameter int DATA_W  = 8,
    parameter int KEEP_W  = (DATA_W + 7) / 8,
    parameter int USR_W   = 1,
    parameter int ID_W    = 1,
    parameter int DEST_W  = 1,
    parameter int MIN_LEN = 1,
    parameter int MAX_LEN = 64,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             srst_n,
    axis_full_if.in          s_axis,
    axis_full_if.out         m_axis,
    output logic             stat_good_frame,
    output logic             stat_bad_frame,
    output logic [LEN_W-1:0] stat_frame_len,
    output logic [31:0]      stat_good_cnt,
    output logic [31:0]      stat_bad_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  beat_cnt;

    // Output register
    logic [DATA_W-1:0] data_q;
    logic [KEEP_W-1:0] keep_q;
    logic              last_q;
    logic [ID_W-1:0]   id_q;
    logic [DEST_W-1:0] dest_q;
    logic [USR_W-1:0]  user_q;
    logic              valid_q;

    logic              s_ready;
    logic              accept;
    logic              load;
    logic [LEN_W-1:0]  next_len;
    logic              at_max;
    logic              undersize;
    logic              oversize;
    logic              is_term;
    logic              len_bad;
    logic              term_good;
    logic              term_bad;

    // While forwarding, accept only when the output register is free or
    // drains this cycle. In DROP nothing is loaded, so accept unconditionally.
    always_comb begin
        s_ready = 1'b0;
        if (srst_n) begin
            if (state == ST_DROP) s_ready = 1'b1;
            else                  s_ready = m_axis.tready || !valid_q;
        end
    end

    assign accept    = s_axis.tvalid && s_ready;
    assign load      = accept && (state != ST_DROP);

    // next_len is the frame length including the beat being accepted.
    assign next_len  = beat_cnt + LEN_W'(1);
    assign at_max    = (next_len == LEN_W'(MAX_LEN));
    assign undersize = s_axis.tlast && (next_len < LEN_W'(MIN_LEN));
    assign oversize  = !s_axis.tlast && at_max;
    assign len_bad   = undersize || oversize;

    // A frame terminates on a real tlast or on the truncation beat.
    assign is_term   = load && (s_axis.tlast || oversize);
    assign term_bad  = is_term && (len_bad || s_axis.tuser[0]);
    assign term_good = is_term && !(len_bad || s_axis.tuser[0]);

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = data_q;
    assign m_axis.tkeep  = keep_q;
    assign m_axis.tlast  = last_q;
    assign m_axis.tid    = id_q;
    assign m_axis.tdest  = dest_q;
    assign m_axis.tuser  = user_q;
    assign m_axis.tvalid = valid_q;
    assign dbg_state     = state;

    // Payload needs no reset: it is only observed while valid_q=1.
    always_ff @(posedge clk) begin
        if (load) begin
            data_q    <= s_axis.tdata;
            keep_q    <= s_axis.tkeep;
            id_q      <= s_axis.tid;
            dest_q    <= s_axis.tdest;
            last_q    <= s_axis.tlast || oversize;
            user_q    <= s_axis.tuser;
            user_q[0] <= s_axis.tuser[0] || len_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state           <= ST_IDLE;
            beat_cnt        <= '0;
            valid_q         <= 1'b0;
            stat_good_frame <= 1'b0;
            stat_bad_frame  <= 1'b0;
            stat_frame_len  <= '0;
        end else begin
            stat_good_frame <= term_good;
            stat_bad_frame  <= term_bad;
            if (is_term) stat_frame_len <= next_len;

            if (load)                valid_q <= 1'b1;
            else if (m_axis.tready)  valid_q <= 1'b0;

            case (state)
                ST_IDLE, ST_ACTIVE: begin
                    if (accept) begin
                        if (s_axis.tlast) begin
                            state    <= ST_IDLE;
                            beat_cnt <= '0;
                        end else if (at_max) begin
                            // Truncated: hold the count at MAX_LEN until the tail ends.
                            state    <= ST_DROP;
                            beat_cnt <= next_len;
                        end else begin
                            state    <= ST_ACTIVE;
                            beat_cnt <= next_len;
                        end
                    end
                end
                ST_DROP: begin
                    if (accept && s_axis.tlast) begin
                        state    <= ST_IDLE;
                        beat_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

`ifdef AXIS_FRAME_LEN_CHECK_STATS_EN
    logic [31:0] good_cnt_q;
    logic [31:0] bad_cnt_q;

    // Counters step together with the pulse registers and stick at all-ones.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            if (term_good && (good_cnt_q != 32'hFFFF_FFFF)) good_cnt_q <= good_cnt_q + 32'd1;
            if (term_bad  && (bad_cnt_q  != 32'hFFFF_FFFF)) bad_cnt_q  <= bad_cnt_q  + 32'd1;
        end
    end

    assign stat_good_cnt = good_cnt_q;
    assign stat_bad_cnt  = bad_cnt_q;
`else
    assign stat_good_cnt = 32'd0;
    assign stat_bad_cnt  = 32'd0;
`endif

endmodule
